// File: rtl/demo_load_sequencer.sv
// -----------------------------------------------------------------------------
// demo_load_sequencer
//
// Bring-up sequencer for the FPGA demo of tt_um_tiny_processor. One run:
// hold the core in reset, release it, command the SPI program driver to
// load, wait for the driver's done, hand the core's serial input over from
// the driver's mosi_out to the external miso, then let the core run.
// A load that never completes ends in a sticky ERROR state.
//
// Optional feature: define DEMO_SEQ_AUTOSTART_EN to leave IDLE on its own
// right after reset (ERROR still waits for a start edge).
//
// Parameters:
//   RST_CYCLES    cycles core_rst_n is held low, and again held high before load
//   SETTLE_CYCLES cycles between bus handover and running
//   LOAD_TIMEOUT  maximum cycles spent in LOAD waiting for the driver's done
//
// Ports:
//   clk         in  system clock (same domain as the driver)
//   rst         in  synchronous active-high reset
//   start       in  start request; only its rising edge is used
//   drv_done    in  driver done_out; only its rising edge is used
//   drv_start   out driver drive command, a level held during LOAD
//   core_rst_n  out core reset, active low
//   sel_dev     out uio_in[4] source: 0 = driver mosi_out, 1 = miso
//   busy        out a sequence is in progress
//   running     out core released and executing
//   error       out load timed out (sticky until the next start edge)
//   state       out FSM state encoding, for LEDs
// -----------------------------------------------------------------------------
module demo_load_sequencer #(
   parameter int RST_CYCLES    = 10,
   parameter int SETTLE_CYCLES = 4,
   parameter int LOAD_TIMEOUT  = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       drv_done,
   output logic       drv_start,
   output logic       core_rst_n,
   output logic       sel_dev,
   output logic       busy,
   output logic       running,
   output logic       error,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HOLD_RST = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_LOAD     = 3'd3,
      ST_HANDOVER = 3'd4,
      ST_RUN      = 3'd5,
      ST_ERROR    = 3'd6
   } state_t;

   // One shared down-counter covers the longest timed state.
   localparam int MAX_RS  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int MAX_CYC = (MAX_RS > LOAD_TIMEOUT) ? MAX_RS : LOAD_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // The counter is loaded with N-1 on entry and the state exits when it
   // reads zero, so the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOAD_TIMEOUT - 1);

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             start_q;
   logic             drv_done_q;
   logic             start_edge_r;
   logic             done_edge_r;
   logic             start_ok_s;
   logic             drv_start_s;
   logic             core_rst_n_s;
   logic             sel_dev_s;
   logic             busy_s;
   logic             running_s;
   logic             error_s;

   // Start edges are only meaningful in the states that accept them; an edge
   // seen while busy is dropped here rather than carried into the next state.
   always_comb begin
      start_ok_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_RUN, ST_ERROR: start_ok_s = 1'b1;
         default:                   start_ok_s = 1'b0;
      endcase
   end

   // Next-state decision from the registered edge pulses and the counter.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
`ifdef DEMO_SEQ_AUTOSTART_EN
            next_state_s = ST_HOLD_RST;
`else
            if (start_edge_r) begin
               next_state_s = ST_HOLD_RST;
            end else begin
               next_state_s = ST_IDLE;
            end
`endif
         end
         ST_HOLD_RST: begin
            if (cnt_r == CNT_ZERO) begin
               next_state_s = ST_RELEASE;
            end else begin
               next_state_s = ST_HOLD_RST;
            end
         end
         ST_RELEASE: begin
            if (cnt_r == CNT_ZERO) begin
               next_state_s = ST_LOAD;
            end else begin
               next_state_s = ST_RELEASE;
            end
         end
         ST_LOAD: begin
            // A done edge beats a timeout expiring in the same cycle.
            if (done_edge_r) begin
               next_state_s = ST_HANDOVER;
            end else if (cnt_r == CNT_ZERO) begin
               next_state_s = ST_ERROR;
            end else begin
               next_state_s = ST_LOAD;
            end
         end
         ST_HANDOVER: begin
            if (cnt_r == CNT_ZERO) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_HANDOVER;
            end
         end
         ST_RUN, ST_ERROR: begin
            if (start_edge_r) begin
               next_state_s = ST_HOLD_RST;
            end else begin
               next_state_s = state_r;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Counter: reload on every state change, otherwise count down and stick at zero.
   always_comb begin
      cnt_next_s = CNT_ZERO;
      if (next_state_s != state_r) begin
         case (next_state_s)
            ST_HOLD_RST, ST_RELEASE: cnt_next_s = RST_LOAD;
            ST_LOAD:                 cnt_next_s = TO_LOAD;
            ST_HANDOVER:             cnt_next_s = SETTLE_LOAD;
            default:                 cnt_next_s = CNT_ZERO;
         endcase
      end else if (cnt_r != CNT_ZERO) begin
         cnt_next_s = cnt_r - CNT_ONE;
      end else begin
         cnt_next_s = CNT_ZERO;
      end
   end

   // Output decode from the next state, so registered outputs move with state.
   always_comb begin
      drv_start_s  = 1'b0;
      core_rst_n_s = 1'b0;
      sel_dev_s    = 1'b0;
      busy_s       = 1'b0;
      running_s    = 1'b0;
      error_s      = 1'b0;
      case (next_state_s)
         ST_IDLE: begin
            core_rst_n_s = 1'b0;
         end
         ST_HOLD_RST: begin
            busy_s = 1'b1;
         end
         ST_RELEASE: begin
            core_rst_n_s = 1'b1;
            busy_s       = 1'b1;
         end
         ST_LOAD: begin
            core_rst_n_s = 1'b1;
            drv_start_s  = 1'b1;
            busy_s       = 1'b1;
         end
         ST_HANDOVER: begin
            core_rst_n_s = 1'b1;
            sel_dev_s    = 1'b1;
            busy_s       = 1'b1;
         end
         ST_RUN: begin
            core_rst_n_s = 1'b1;
            sel_dev_s    = 1'b1;
            running_s    = 1'b1;
         end
         ST_ERROR: begin
            error_s = 1'b1;
         end
         default: begin
            core_rst_n_s = 1'b0;
         end
      endcase
   end

   // State, counter, edge detectors and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         start_q      <= 1'b0;
         drv_done_q   <= 1'b0;
         start_edge_r <= 1'b0;
         done_edge_r  <= 1'b0;
         state        <= 3'd0;
         drv_start    <= 1'b0;
         core_rst_n   <= 1'b0;
         sel_dev      <= 1'b0;
         busy         <= 1'b0;
         running      <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         cnt_r        <= cnt_next_s;
         start_q      <= start;
         drv_done_q   <= drv_done;
         start_edge_r <= start & ~start_q & start_ok_s;
         // Done only counts as a rising edge seen while already in LOAD, so
         // a done that was high before LOAD is never mistaken for one.
         done_edge_r  <= drv_done & ~drv_done_q & (state_r == ST_LOAD);
         state        <= next_state_s;
         drv_start    <= drv_start_s;
         core_rst_n   <= core_rst_n_s;
         sel_dev      <= sel_dev_s;
         busy         <= busy_s;
         running      <= running_s;
         error        <= error_s;
      end
   end

endmodule

// File: tb/tb_demo_load_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for demo_load_sequencer. Two instances share the clock:
//   dutA: RST_CYCLES=10, SETTLE_CYCLES=4, LOAD_TIMEOUT=65535 (nominal, restart,
//         stale done, start ignored in LOAD, reset mid-LOAD)
//   dutB: RST_CYCLES=10, SETTLE_CYCLES=4, LOAD_TIMEOUT=50 (timeout, restart
//         from ERROR, done edge on the exact timeout cycle)
// The stimulus pushes every expected output change (vector + cycle) into a
// per-instance queue; a monitor per instance pops and compares each time that
// instance's outputs change.
// -----------------------------------------------------------------------------
module tb_demo_load_sequencer;

   localparam int S_IDLE = 0, S_HOLD = 1, S_REL = 2, S_LOAD = 3,
                  S_HAND = 4, S_RUN = 5, S_ERR = 6;

   typedef struct packed {
      logic [8:0] vec;
      int         cyc;
      int         step;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   step_a = 0;
   int   step_b = 0;
   bit   mon_en = 1'b0;

   logic rst_a = 1'b1, start_a = 1'b0, done_a = 1'b0;
   logic rst_b = 1'b1, start_b = 1'b0, done_b = 1'b0;
   logic drv_start_a, core_rst_n_a, sel_dev_a, busy_a, running_a, error_a;
   logic drv_start_b, core_rst_n_b, sel_dev_b, busy_b, running_b, error_b;
   logic [2:0] state_a, state_b;
   logic [8:0] obs_a, obs_b, prev_a, prev_b;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   demo_load_sequencer #(.RST_CYCLES(10), .SETTLE_CYCLES(4), .LOAD_TIMEOUT(65535)) u_dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .drv_done(done_a),
      .drv_start(drv_start_a), .core_rst_n(core_rst_n_a), .sel_dev(sel_dev_a),
      .busy(busy_a), .running(running_a), .error(error_a), .state(state_a));

   demo_load_sequencer #(.RST_CYCLES(10), .SETTLE_CYCLES(4), .LOAD_TIMEOUT(50)) u_dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .drv_done(done_b),
      .drv_start(drv_start_b), .core_rst_n(core_rst_n_b), .sel_dev(sel_dev_b),
      .busy(busy_b), .running(running_b), .error(error_b), .state(state_b));

   assign obs_a = {state_a, core_rst_n_a, drv_start_a, sel_dev_a, busy_a, running_a, error_a};
   assign obs_b = {state_b, core_rst_n_b, drv_start_b, sel_dev_b, busy_b, running_b, error_b};

   // Expected outputs per state: {state, core_rst_n, drv_start, sel_dev, busy, running, error}
   function automatic logic [8:0] exp_vec(input int st);
      case (st)
         S_IDLE:  exp_vec = {3'd0, 6'b000000};
         S_HOLD:  exp_vec = {3'd1, 6'b000100};
         S_REL:   exp_vec = {3'd2, 6'b100100};
         S_LOAD:  exp_vec = {3'd3, 6'b110100};
         S_HAND:  exp_vec = {3'd4, 6'b101100};
         S_RUN:   exp_vec = {3'd5, 6'b101010};
         S_ERR:   exp_vec = {3'd6, 6'b000001};
         default: exp_vec = 9'h1FF;
      endcase
   endfunction

   task automatic push_a(input int st, input int c);
      exp_t e;
      e.vec = exp_vec(st); e.cyc = c; e.step = step_a;
      step_a++;
      q_a.push_back(e);
   endtask

   task automatic push_b(input int st, input int c);
      exp_t e;
      e.vec = exp_vec(st); e.cyc = c; e.step = step_b;
      step_b++;
      q_b.push_back(e);
   endtask

   task automatic check_item(input string dut, input exp_t e, input logic [8:0] got, input int got_cyc);
      checks++;
      if (got !== e.vec) begin
         errors++;
         $display("FAIL %s step%0d vector: got %b, required %b", dut, e.step, got, e.vec);
      end
      checks++;
      if (got_cyc != e.cyc) begin
         errors++;
         $display("FAIL %s step%0d timing: changed at cycle %0d, required cycle %0d", dut, e.step, got_cyc, e.cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Start pulse driven at the current negedge (cycle k); sampled at edge k+1.
   task automatic pulse_start(input int which);
      if (which == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Monitor for dutA: every output change must match the next expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && (obs_a !== prev_a)) begin
            prev_a = obs_a;
            if (q_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL dutA unexpected_change: got %b at cycle %0d, required no change", obs_a, cyc);
            end else begin
               e = q_a.pop_front();
               check_item("dutA", e, obs_a, cyc);
            end
         end
      end
   end

   // Monitor for dutB.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && (obs_b !== prev_b)) begin
            prev_b = obs_b;
            if (q_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL dutB unexpected_change: got %b at cycle %0d, required no change", obs_b, cyc);
            end else begin
               e = q_b.pop_front();
               check_item("dutB", e, obs_b, cyc);
            end
         end
      end
   end

   // Stimulus: every expected change is pushed before the input that causes it.
   initial begin
      int k;
      int l;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_a !== exp_vec(S_IDLE)) begin
         errors++;
         $display("FAIL dutA reset_state: got %b, required %b", obs_a, exp_vec(S_IDLE));
      end
      checks++;
      if (obs_b !== exp_vec(S_IDLE)) begin
         errors++;
         $display("FAIL dutB reset_state: got %b, required %b", obs_b, exp_vec(S_IDLE));
      end
      prev_a = exp_vec(S_IDLE);
      prev_b = exp_vec(S_IDLE);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // dutA nominal: done rises 200 cycles after drv_start
      k = cyc; l = k + 22;
      push_a(S_HOLD, k + 2); push_a(S_REL, k + 12); push_a(S_LOAD, l);
      pulse_start(0);
      wait_until(l + 199);
      push_a(S_HAND, l + 201); push_a(S_RUN, l + 205);
      done_a = 1'b1;
      wait_until(l + 210);
      done_a = 1'b0;
      repeat (3) @(negedge clk);

      // dutA restart from RUN, stale done before LOAD, start ignored in LOAD
      k = cyc;
      push_a(S_HOLD, k + 2); push_a(S_REL, k + 12); push_a(S_LOAD, k + 22);
      pulse_start(0);
      wait_until(k + 12);
      done_a = 1'b1;
      wait_until(k + 25);
      pulse_start(0);
      wait_until(k + 30);
      done_a = 1'b0;
      wait_until(k + 33);
      push_a(S_HAND, k + 35); push_a(S_RUN, k + 39);
      done_a = 1'b1;
      wait_until(k + 45);
      done_a = 1'b0;
      repeat (2) @(negedge clk);

      // dutA reset mid-LOAD
      k = cyc;
      push_a(S_HOLD, k + 2); push_a(S_REL, k + 12); push_a(S_LOAD, k + 22);
      pulse_start(0);
      wait_until(k + 30);
      push_a(S_IDLE, k + 31);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (obs_a !== exp_vec(S_IDLE)) begin
         errors++;
         $display("FAIL dutA idle_after_reset: got %b, required %b", obs_a, exp_vec(S_IDLE));
      end

      // dutB timeout after exactly 50 LOAD cycles
      k = cyc; l = k + 22;
      push_b(S_HOLD, k + 2); push_b(S_REL, k + 12); push_b(S_LOAD, l);
      push_b(S_ERR, l + 50);
      pulse_start(1);
      wait_until(l + 60);

      // dutB restart from ERROR; done edge lands on the timeout cycle
      k = cyc; l = k + 22;
      push_b(S_HOLD, k + 2); push_b(S_REL, k + 12); push_b(S_LOAD, l);
      pulse_start(1);
      wait_until(l + 48);
      push_b(S_HAND, l + 50); push_b(S_RUN, l + 54);
      done_b = 1'b1;
      wait_until(l + 60);
      done_b = 1'b0;
      repeat (10) @(negedge clk);

      checks++;
      if (q_a.size() != 0) begin
         errors++;
         $display("FAIL dutA pending_changes: got %0d outstanding, required 0", q_a.size());
      end
      checks++;
      if (q_b.size() != 0) begin
         errors++;
         $display("FAIL dutB pending_changes: got %0d outstanding, required 0", q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
